debug_unit: RTL and testbench
=============================

DEBUG_UNIT -- requirements
Module: debug_unit

Interface
REQ-001 SHALL have parameters: FRAME_BYTES, default 173, bytes per dump frame (1 sync byte + 172 data bytes); SYNC_BYTE, default 8'hA5, first byte of every frame.
REQ-002 SHALL have ports: clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have ports: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports: rx_data  input  8  received command byte; rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-005 SHALL have ports: tx_ready  input  1  UART transmitter idle; tx_start  output  1  one-cycle send strobe; tx_data  output  8  byte to send.
REQ-006 SHALL have ports: pipe_enable  output  1  pipeline enable; pipe_rst  output  1  pipeline reset pulse.
REQ-007 SHALL have ports: pc  input  8; if_id  input  40; id_ex  input  144; ex_m  input  80; m_wb  input  80; registros  input  1024; all are pipeline debug state.

Function
REQ-008 SHALL implement states HALT, RUN, STEP, SNAP, SEND, WAIT_TX.
REQ-009 SHALL decode commands only on rx_valid=1: 'c' (8'h63) run, 'h' (8'h68) halt, 's' (8'h73) step, 'd' (8'h64) dump, 'r' (8'h72) pipeline reset; any other byte is ignored.
REQ-010 SHALL, in HALT: 'c' -> RUN; 's' -> STEP; 'd' -> SNAP; 'r' -> pipe_rst=1 for exactly one cycle, stay HALT; 'h' -> no effect.
REQ-011 SHALL hold pipe_enable=1 in every RUN cycle and 0 in all other states except STEP.
REQ-012 SHALL, in RUN, accept only 'h': pipe_enable=0 from the next cycle, then HALT; all other commands are ignored.
REQ-013 SHALL drive pipe_enable=1 for exactly one cycle in STEP, then enter SNAP (automatic dump after each step).
REQ-014 SHALL, in SNAP, latch {pc, if_id, id_ex, ex_m, m_wb, registros} (1376 bits) into a snapshot register in one cycle, clear the byte index to 0, and enter SEND.
REQ-015 SHALL send frame byte 0 = SYNC_BYTE, then snapshot bytes 1..172 MSB-first: pc, if_id[39:32] ... registros[7:0].
REQ-016 SHALL, in SEND with tx_ready=1, present tx_data = frame byte[index], pulse tx_start for one cycle, and enter WAIT_TX; with tx_ready=0, SHALL wait in SEND.
REQ-017 SHALL, in WAIT_TX, wait at least one cycle, then on tx_ready=1 increment the index and return to SEND, or go to HALT after index FRAME_BYTES-1.
REQ-018 SHALL hold tx_data stable from the tx_start cycle until the next tx_start.
REQ-019 SHALL ignore rx_valid in STEP, SNAP, SEND and WAIT_TX; commands received then are dropped, not queued.
REQ-020 SHALL keep the snapshot unchanged during SEND/WAIT_TX even though pipeline inputs may change.
REQ-021 SHALL never assert tx_start and pipe_enable in the same cycle.

Reset
REQ-022 SHALL, on rst=1 at a clk edge: state=HALT, pipe_enable=0, pipe_rst=0, tx_start=0, tx_data=8'h00, index=0, snapshot=0.
REQ-023 SHALL, if rst arrives mid-frame, abort the frame with no further tx_start after the reset cycle.
REQ-024 SHALL ignore rx_valid in the reset cycle.

Structure
REQ-025 SHALL place in shared package debug_pkg: the command byte constants, SYNC_BYTE, FRAME_BYTES, SNAP_BITS=1376, and the state enumeration.
REQ-026 SHALL use one sub-module, debug_snapshot: it holds the 1376-bit capture register and returns the frame byte selected by the index.

Verification
REQ-027 SHALL cover: reset, then 'c' -> pipe_enable=1 from the next cycle; then 'h' -> pipe_enable=0 within 1 cycle; state HALT.
REQ-028 SHALL cover: 's' in HALT -> exactly one pipe_enable cycle, then 173 tx_start pulses; byte0=8'hA5 and byte1=pc.
REQ-029 SHALL cover: 'd' with registros[1023:1016]=8'h3C and registros[7:0]=8'hC3 -> frame byte 45=8'h3C and byte 172=8'hC3.
REQ-030 SHALL cover: tx_ready held 0 for 50 cycles mid-frame -> no tx_start, tx_data stable, frame resumes at the same index.
REQ-031 SHALL cover: 'c' and 'd' sent during SEND -> ignored; state HALT after the frame ends; pipe_enable=0 throughout.
REQ-032 SHALL cover: rst asserted after byte 20 -> tx_start=0 thereafter, state HALT; then 'r' -> one-cycle pipe_rst pulse.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared constants and state encoding for the pipeline debug unit.
package debug_pkg;

    localparam logic [7:0] CMD_RUN  = 8'h63;
    localparam logic [7:0] CMD_HALT = 8'h68;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_DUMP = 8'h64;
    localparam logic [7:0] CMD_RST  = 8'h72;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         FRAME_BYTES = 173;
    localparam int         SNAP_BITS   = 1376;
    localparam int         SNAP_BYTES  = SNAP_BITS / 8;
    localparam int         IDX_W       = 8;

    typedef enum logic [2:0] {
        HALT,
        RUN,
        STEP,
        SNAP,
        SEND,
        WAIT_TX
    } state_t;

endpackage

// File: rtl/debug_snapshot.sv
// Capture register for the pipeline debug state; returns the frame byte at a given index
// (index 0 is the sync byte, then snapshot bytes most-significant first).
module debug_snapshot
    import debug_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = debug_pkg::SYNC_BYTE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 capture,
    input  logic [SNAP_BITS-1:0] state_in,
    input  logic [IDX_W-1:0]     index,
    output logic [7:0]           frame_byte
);

    logic [SNAP_BITS-1:0] snap;
    logic [IDX_W-1:0]     rev;
    logic [IDX_W+2:0]     lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            snap <= '0;
        end else if (capture) begin
            snap <= state_in;
        end
    end

    // Byte k (1..SNAP_BYTES) sits (SNAP_BYTES-k) bytes above the LSB.
    assign rev = IDX_W'(SNAP_BYTES) - index;
    assign lo  = {rev, 3'b000};

    always_comb begin
        frame_byte = '0;
        if (index == '0) begin
            frame_byte = SYNC_BYTE;
        end else if (index <= IDX_W'(SNAP_BYTES)) begin
            frame_byte = snap[lo +: 8];
        end
    end

endmodule

// File: rtl/debug_unit.sv
// UART-driven debug controller: run/halt/step the pipeline and dump its state
// as a sync-prefixed byte frame.
module debug_unit
    import debug_pkg::*;
#(
    parameter int         FRAME_BYTES = debug_pkg::FRAME_BYTES,
    parameter logic [7:0] SYNC_BYTE   = debug_pkg::SYNC_BYTE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    input  logic          tx_ready,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    output logic          pipe_enable,
    output logic          pipe_rst,
    input  logic [7:0]    pc,
    input  logic [39:0]   if_id,
    input  logic [143:0]  id_ex,
    input  logic [79:0]   ex_m,
    input  logic [79:0]   m_wb,
    input  logic [1023:0] registros
);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] index, index_nxt;
    logic             capture;
    logic             tx_fire;
    logic             pipe_rst_nxt;
    logic [7:0]       frame_byte;

    debug_snapshot #(
        .SYNC_BYTE (SYNC_BYTE)
    ) u_snapshot (
        .clk        (clk),
        .rst        (rst),
        .capture    (capture),
        .state_in   ({pc, if_id, id_ex, ex_m, m_wb, registros}),
        .index      (index),
        .frame_byte (frame_byte)
    );

    always_comb begin
        state_nxt    = state;
        index_nxt    = index;
        capture      = 1'b0;
        tx_fire      = 1'b0;
        pipe_rst_nxt = 1'b0;
        case (state)
            HALT: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_RUN:  state_nxt    = RUN;
                        CMD_STEP: state_nxt    = STEP;
                        CMD_DUMP: state_nxt    = SNAP;
                        CMD_RST:  pipe_rst_nxt = 1'b1;
                        default:  ;
                    endcase
                end
            end
            RUN: begin
                if (rx_valid && rx_data == CMD_HALT) state_nxt = HALT;
            end
            STEP: state_nxt = SNAP;
            SNAP: begin
                capture   = 1'b1;
                index_nxt = '0;
                state_nxt = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    tx_fire   = 1'b1;
                    state_nxt = WAIT_TX;
                end
            end
            WAIT_TX: begin
                // tx_start is still high in the first WAIT_TX cycle, which
                // masks a tx_ready the transmitter has not yet dropped.
                if (!tx_start && tx_ready) begin
                    if (index == IDX_W'(FRAME_BYTES - 1)) begin
                        state_nxt = HALT;
                    end else begin
                        index_nxt = index + 1'b1;
                        state_nxt = SEND;
                    end
                end
            end
            default: state_nxt = HALT;
        endcase
    end

    assign pipe_enable = (state == RUN) || (state == STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HALT;
            index    <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            pipe_rst <= 1'b0;
        end else begin
            state    <= state_nxt;
            index    <= index_nxt;
            tx_start <= tx_fire;
            pipe_rst <= pipe_rst_nxt;
            if (tx_fire) tx_data <= frame_byte;
        end
    end

endmodule

// File: tb/tb_debug_unit.sv
// Scoreboard bench for debug_unit: expected frames are queued when a dump is
// commanded and popped as the DUT emits bytes.
module tb_debug_unit;
    import debug_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          tx_ready;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          pipe_enable;
    logic          pipe_rst;
    logic [7:0]    pc;
    logic [39:0]   if_id;
    logic [143:0]  id_ex;
    logic [79:0]   ex_m;
    logic [79:0]   m_wb;
    logic [1023:0] registros;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got[0:255];
    int         byte_cnt = 0;
    int         busy = 0;
    logic       stall = 1'b0;

    debug_unit dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_ready    (tx_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .pipe_enable (pipe_enable),
        .pipe_rst    (pipe_rst),
        .pc          (pc),
        .if_id       (if_id),
        .id_ex       (id_ex),
        .ex_m        (ex_m),
        .m_wb        (m_wb),
        .registros   (registros)
    );

    always #5 clk = ~clk;

    // UART transmitter model: busy for a few cycles after each tx_start.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) busy = 3;
            else if (busy > 0) busy--;
            tx_ready = (busy == 0) && !stall;
        end
    end

    // Output monitor: pops the scoreboard on every emitted byte.
    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                if (byte_cnt < 256) got[byte_cnt] = tx_data;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL tx_byte[%0d] unexpected: got %02h, required no transmission", byte_cnt, tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        n_err++;
                        $display("FAIL tx_byte[%0d]: got %02h, required %02h", byte_cnt, tx_data, e);
                    end
                end
                n_cmp++;
                if (pipe_enable !== 1'b0) begin
                    n_err++;
                    $display("FAIL tx_pe_overlap: pipe_enable=%b, required 0 with tx_start", pipe_enable);
                end
                byte_cnt++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1, "watchdog");
    end

    task automatic rand_state();
        pc    = 8'($urandom);
        if_id = {$urandom, 8'($urandom)};
        id_ex = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
        ex_m  = {$urandom, $urandom, 16'($urandom)};
        m_wb  = {$urandom, $urandom, 16'($urandom)};
        for (int i = 0; i < 32; i++) registros[i*32 +: 32] = $urandom;
    endtask

    task automatic push_frame();
        logic [1375:0] tmp;
        tmp = {pc, if_id, id_ex, ex_m, m_wb, registros};
        exp_q.push_back(8'hA5);
        for (int k = 0; k < 172; k++) begin
            exp_q.push_back(tmp[1375:1368]);
            tmp = tmp << 8;
        end
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (byte_cnt >= n) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL wait_bytes: got %0d bytes, required %0d", byte_cnt, n);
        end
    endtask

    task automatic wait_frame(output int pe_cnt);
        bit ok;
        ok = 0;
        pe_cnt = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (pipe_enable === 1'b1) pe_cnt++;
            if (byte_cnt >= 173 && dut.state == HALT) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL wait_frame: got %0d bytes, required 173 then HALT", byte_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b1; rx_data = CMD_RUN;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; rx_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (pipe_enable !== 1'b0) begin n_err++; $display("FAIL reset_pe: got %b, required 0", pipe_enable); end
        n_cmp++; if (pipe_rst !== 1'b0) begin n_err++; $display("FAIL reset_prst: got %b, required 0", pipe_rst); end
        n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL reset_txs: got %b, required 0", tx_start); end
        n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_txd: got %02h, required 00", tx_data); end
        n_cmp++; if (dut.state !== HALT) begin n_err++; $display("FAIL reset_state: got %0d, required HALT", dut.state); end
        @(negedge clk);
        n_cmp++; if (pipe_enable !== 1'b0) begin n_err++; $display("FAIL reset_rx_ignored: pe got %b, required 0", pipe_enable); end
    endtask

    task automatic test_run_halt();
        int bad;
        send_cmd(CMD_RUN);
        @(negedge clk);
        n_cmp++; if (pipe_enable !== 1'b1) begin n_err++; $display("FAIL run_pe: got %b, required 1", pipe_enable); end
        bad = 0;
        repeat (5) begin @(negedge clk); if (pipe_enable !== 1'b1) bad++; end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL run_hold: %0d low cycles, required 0", bad); end
        send_cmd(CMD_DUMP);
        send_cmd(CMD_STEP);
        @(negedge clk);
        n_cmp++; if (pipe_enable !== 1'b1) begin n_err++; $display("FAIL run_ignore_pe: got %b, required 1", pipe_enable); end
        n_cmp++; if (byte_cnt !== 0) begin n_err++; $display("FAIL run_ignore_tx: got %0d bytes, required 0", byte_cnt); end
        send_cmd(CMD_HALT);
        @(negedge clk);
        n_cmp++; if (pipe_enable !== 1'b0) begin n_err++; $display("FAIL halt_pe: got %b, required 0", pipe_enable); end
        n_cmp++; if (dut.state !== HALT) begin n_err++; $display("FAIL halt_state: got %0d, required HALT", dut.state); end
    endtask

    task automatic test_step();
        int pe;
        byte_cnt = 0;
        rand_state();
        pc = 8'h5A;
        push_frame();
        send_cmd(CMD_STEP);
        wait_frame(pe);
        n_cmp++; if (pe != 1) begin n_err++; $display("FAIL step_pe_cycles: got %0d, required 1", pe); end
        n_cmp++; if (byte_cnt != 173) begin n_err++; $display("FAIL step_bytes: got %0d, required 173", byte_cnt); end
        n_cmp++; if (got[0] !== 8'hA5) begin n_err++; $display("FAIL step_sync: got %02h, required a5", got[0]); end
        n_cmp++; if (got[1] !== 8'h5A) begin n_err++; $display("FAIL step_pc: got %02h, required 5a", got[1]); end
    endtask

    task automatic test_dump();
        int pe;
        byte_cnt = 0;
        rand_state();
        registros[1023:1016] = 8'h3C;
        registros[7:0]       = 8'hC3;
        push_frame();
        send_cmd(CMD_DUMP);
        wait_bytes(3);
        rand_state();
        wait_frame(pe);
        n_cmp++; if (got[45] !== 8'h3C) begin n_err++; $display("FAIL dump_byte45: got %02h, required 3c", got[45]); end
        n_cmp++; if (got[172] !== 8'hC3) begin n_err++; $display("FAIL dump_byte172: got %02h, required c3", got[172]); end
        n_cmp++; if (pe != 0) begin n_err++; $display("FAIL dump_pe: got %0d cycles, required 0", pe); end
    endtask

    task automatic test_stall();
        int pe, starts, moved;
        logic [7:0] held;
        byte_cnt = 0;
        rand_state();
        push_frame();
        send_cmd(CMD_DUMP);
        wait_bytes(10);
        stall = 1'b1;
        @(negedge clk);
        held = tx_data;
        starts = 0; moved = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_start !== 1'b0) starts++;
            if (tx_data !== held) moved++;
        end
        n_cmp++; if (starts != 0) begin n_err++; $display("FAIL stall_txs: got %0d pulses, required 0", starts); end
        n_cmp++; if (moved != 0) begin n_err++; $display("FAIL stall_txd: changed %0d cycles, required 0", moved); end
        n_cmp++; if (byte_cnt != 10) begin n_err++; $display("FAIL stall_count: got %0d, required 10", byte_cnt); end
        stall = 1'b0;
        wait_frame(pe);
        n_cmp++; if (byte_cnt != 173) begin n_err++; $display("FAIL stall_resume: got %0d bytes, required 173", byte_cnt); end
    endtask

    task automatic test_ignore();
        int pe;
        byte_cnt = 0;
        rand_state();
        push_frame();
        send_cmd(CMD_DUMP);
        wait_bytes(5);
        send_cmd(CMD_RUN);
        @(negedge clk);
        n_cmp++; if (pipe_enable !== 1'b0) begin n_err++; $display("FAIL ignore_run_pe: got %b, required 0", pipe_enable); end
        wait_bytes(40);
        send_cmd(CMD_DUMP);
        send_cmd(CMD_STEP);
        wait_frame(pe);
        n_cmp++; if (pe != 0) begin n_err++; $display("FAIL ignore_pe: got %0d cycles, required 0", pe); end
        n_cmp++; if (dut.state !== HALT) begin n_err++; $display("FAIL ignore_state: got %0d, required HALT", dut.state); end
        repeat (30) @(negedge clk);
        n_cmp++; if (byte_cnt != 173) begin n_err++; $display("FAIL ignore_no_requeue: got %0d bytes, required 173", byte_cnt); end
        n_cmp++; if (pipe_enable !== 1'b0) begin n_err++; $display("FAIL ignore_pe_after: got %b, required 0", pipe_enable); end
    endtask

    task automatic test_reset_midframe();
        int saved, starts, prst;
        byte_cnt = 0;
        rand_state();
        push_frame();
        send_cmd(CMD_DUMP);
        wait_bytes(21);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        saved = byte_cnt;
        @(negedge clk);
        n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL midrst_txd: got %02h, required 00", tx_data); end
        n_cmp++; if (dut.state !== HALT) begin n_err++; $display("FAIL midrst_state: got %0d, required HALT", dut.state); end
        starts = 0;
        repeat (200) begin @(negedge clk); if (tx_start !== 1'b0) starts++; end
        n_cmp++; if (starts != 0) begin n_err++; $display("FAIL midrst_txs: got %0d pulses, required 0", starts); end
        n_cmp++; if (byte_cnt != saved) begin n_err++; $display("FAIL midrst_count: got %0d, required %0d", byte_cnt, saved); end
        send_cmd(CMD_RST);
        @(negedge clk);
        n_cmp++; if (pipe_rst !== 1'b1) begin n_err++; $display("FAIL prst_pulse: got %b, required 1", pipe_rst); end
        prst = 1;
        repeat (6) begin @(negedge clk); if (pipe_rst !== 1'b0) prst++; end
        n_cmp++; if (prst != 1) begin n_err++; $display("FAIL prst_width: got %0d cycles, required 1", prst); end
        n_cmp++; if (dut.state !== HALT) begin n_err++; $display("FAIL prst_state: got %0d, required HALT", dut.state); end
        n_cmp++; if (pipe_enable !== 1'b0) begin n_err++; $display("FAIL prst_pe: got %b, required 0", pipe_enable); end
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        rand_state();
        test_reset();
        test_run_halt();
        test_step();
        test_dump();
        test_stall();
        test_ignore();
        test_reset_midframe();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d bytes left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
